// File: rtl/skein_pkg.sv
// Shared definitions for the Skein-1024 hash scoring slice: bus widths,
// the "no best yet" distance marker and the scorer FSM state encoding.
package skein_pkg;

  // Width of a finished Skein-1024 hash.
  localparam int HASH_W  = 1024;

  // Width of the nonce that produced a hash.
  localparam int NONCE_W = 256;

  // Width of a Hamming distance. It must hold 0..1024.
  localparam int DIST_W  = 11;

  // Best-distance value that means no hash has been scored yet.
  localparam logic [DIST_W-1:0] DIST_NONE = 11'h7FF;

  // Scorer phases: waiting for a hash, summing chunk popcounts, updating the best.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_COMPARE = 2'd2
  } scoreState_e;

endpackage

// File: rtl/hash_distance_scorer_popcount_chunk.sv
// Combinational population count of one W-bit slice of the hash/target
// difference. The result is $clog2(W)+1 bits wide, so it can hold the
// all-ones case (count == W).
module popcount_chunk #(
  parameter  int W     = 64,
  localparam int OUT_W = $clog2(W) + 1
) (
  input  logic [W-1:0]     bits_i,
  output logic [OUT_W-1:0] count_o
);

  // Count the set bits by adding each bit to a running sum.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + OUT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/hash_distance_scorer.sv
// Scores each finished Skein-1024 hash by its Hamming distance to the
// target. It sums CHUNK_W bits per cycle over NUM_CHUNKS cycles and
// keeps the lowest distance seen, together with the nonce that produced it.
// Optional feature: define HASH_SCORE_THRESHOLD_EN to add threshold_i/hit_o.
// With that feature, hit_o is a sticky flag. It is set by any score that is
// at or below the threshold.
module hash_distance_scorer
  import skein_pkg::*;
#(
  parameter int CHUNK_W = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [HASH_W-1:0]  hash_i,
  input  logic               hash_valid_i,
  input  logic [NONCE_W-1:0] nonce_i,
  input  logic [HASH_W-1:0]  target_i,
  output logic               busy_o,
  output logic [DIST_W-1:0]  score_o,
  output logic               score_valid_o,
  output logic               new_best_o,
  output logic [DIST_W-1:0]  best_distance_o,
  output logic [NONCE_W-1:0] best_nonce_o,
  output logic               overrun_o
`ifdef HASH_SCORE_THRESHOLD_EN
  ,
  input  logic [DIST_W-1:0]  threshold_i,
  output logic               hit_o
`endif
);

  localparam int NUM_CHUNKS = HASH_W / CHUNK_W;
  localparam int CNT_W      = $clog2(NUM_CHUNKS);
  localparam int POP_W      = $clog2(CHUNK_W) + 1;

  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  scoreState_e        state_q;
  logic [CNT_W-1:0]   chunk_q;
  logic [DIST_W-1:0]  acc_q;
  logic [DIST_W-1:0]  acc_d;
  logic [HASH_W-1:0]  diff_q;
  logic [HASH_W-1:0]  diff_d;
  logic [NONCE_W-1:0] nonce_q;
  logic [DIST_W-1:0]  score_q;
  logic               scoreValid_q;
  logic               newBest_q;
  logic [DIST_W-1:0]  bestDist_q;
  logic [NONCE_W-1:0] bestNonce_q;
  logic               overrun_q;
  logic [POP_W-1:0]   chunkPop;

  // The difference register is shifted down one chunk per cycle. As a result,
  // the popcounter always sees the low CHUNK_W bits. That slice is
  // diff[chunk*CHUNK_W +: CHUNK_W] of the originally latched difference.
  popcount_chunk #(
    .W (CHUNK_W)
  ) u_popcount (
    .bits_i  (diff_q[CHUNK_W-1:0]),
    .count_o (chunkPop)
  );

  // Next accumulator value and next difference window for the ACCUM phase.
  always_comb begin
    acc_d  = acc_q + DIST_W'(chunkPop);
    diff_d = diff_q >> CHUNK_W;
  end

  // Scoring FSM together with every registered result output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      chunk_q      <= '0;
      acc_q        <= '0;
      diff_q       <= '0;
      nonce_q      <= '0;
      score_q      <= '0;
      scoreValid_q <= 1'b0;
      newBest_q    <= 1'b0;
      bestDist_q   <= DIST_NONE;
      bestNonce_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      scoreValid_q <= 1'b0;
      newBest_q    <= 1'b0;

      if (hash_valid_i && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (hash_valid_i) begin
            diff_q  <= hash_i ^ target_i;
            nonce_q <= nonce_i;
            acc_q   <= '0;
            chunk_q <= '0;
            state_q <= ST_ACCUM;
          end
        end

        ST_ACCUM: begin
          acc_q   <= acc_d;
          diff_q  <= diff_d;
          chunk_q <= chunk_q + CNT_W'(1);
          if (chunk_q == LAST_CHUNK) begin
            state_q <= ST_COMPARE;
          end
        end

        ST_COMPARE: begin
          score_q      <= acc_q;
          scoreValid_q <= 1'b1;
          if (acc_q < bestDist_q) begin
            bestDist_q  <= acc_q;
            bestNonce_q <= nonce_q;
            newBest_q   <= 1'b1;
          end
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef HASH_SCORE_THRESHOLD_EN
  logic hit_q;

  // Sticky hit flag, set by any finished score at or below the threshold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_q <= 1'b0;
    end else if ((state_q == ST_COMPARE) && (acc_q <= threshold_i)) begin
      hit_q <= 1'b1;
    end
  end

  assign hit_o = hit_q;
`else
  // This build has no threshold tracking. All other scorer behaviour is unchanged.
`endif

  assign busy_o          = (state_q != ST_IDLE);
  assign score_o         = score_q;
  assign score_valid_o   = scoreValid_q;
  assign new_best_o      = newBest_q;
  assign best_distance_o = bestDist_q;
  assign best_nonce_o    = bestNonce_q;
  assign overrun_o       = overrun_q;

endmodule
